crc_checker: RTL and testbench

Receive-side CRC checker for the MAC datapath, the counterpart of the CRC generator on the transmit side. It consumes a byte stream whose last CRC_WIDTH/DATA_WIDTH beats carry the frame check sequence and forwards the payload with the FCS stripped. It recomputes the CRC over the payload using the generator's polynomial, seed and bit order. At end of frame it reports good/bad/runt status.

---
 rtl/crc_checker.sv | 79 +++++++
 tb/tb_crc_checker.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_checker.sv
// crc_checker: receive-side CRC check that strips the trailing FCS and reports good/bad/runt per frame
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_data/in_valid/in_last   incoming frame beats, in_last marks the final FCS beat
//   out_data/out_valid/out_last payload beats with the FCS removed
//   crc_done                   one-cycle end-of-frame strobe
//   crc_ok/crc_runt/crc_value  frame status and computed CRC, held until the next crc_done
module crc_checker #(
  parameter int CRC_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLYNOMIAL = CRC_WIDTH'(32'h04C11DB7),
  parameter logic [CRC_WIDTH-1:0] SEED = '1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  crc_done,
  output logic                  crc_ok,
  output logic                  crc_runt,
  output logic [CRC_WIDTH-1:0]  crc_value
);
  localparam int N = CRC_WIDTH / DATA_WIDTH;
  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] NF = FW'(N);
  logic [FW-1:0] fill;
  logic [CRC_WIDTH-1:0] win, win_next, crc, crc_next;
  logic [DATA_WIDTH-1:0] oldest;
  logic stream;
  function automatic logic [CRC_WIDTH-1:0] crc_step(input logic [CRC_WIDTH-1:0] c, input logic [DATA_WIDTH-1:0] d);
    logic fb;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb = c[CRC_WIDTH-1] ^ d[i];
      c = (c << 1) ^ (fb ? POLYNOMIAL : '0);
    end
    return c;
  endfunction
  // The delay line holds the last N beats; once full, its oldest beat is payload and
  // at in_last its shifted contents are exactly the received FCS, MS beat first.
  always_comb begin
    stream = fill == NF;
    oldest = win[CRC_WIDTH-1 -: DATA_WIDTH];
    win_next = (win << DATA_WIDTH) | CRC_WIDTH'(in_data);
    crc_next = crc_step(crc, oldest);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill <= '0;
      win <= '0;
      crc <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      crc_done <= 1'b0;
      crc_ok <= 1'b0;
      crc_runt <= 1'b0;
      crc_value <= '0;
    end else begin
      out_valid <= in_valid && stream;
      out_last <= in_valid && in_last && stream;
      crc_done <= in_valid && in_last;
      if (in_valid) begin
        win <= win_next;
        fill <= in_last ? '0 : fill + FW'(!stream);
        crc <= (fill == '0) ? SEED : stream ? crc_next : crc;
        if (stream) out_data <= oldest;
        if (in_last) begin
          crc_ok <= stream && (win_next == crc_next);
          crc_runt <= !stream;
          crc_value <= stream ? crc_next : SEED;
        end
      end
    end
  end
endmodule

// File: tb/tb_crc_checker.sv
// tb_crc_checker: table-driven, directed and random checks of two crc_checker configurations
module tb_crc_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = '0;
  logic in_valid = 1'b0, in_last = 1'b0;
  logic [7:0] a_od, b_od;
  logic a_ov, a_ol, a_done, a_ok, a_runt, b_ov, b_ol, b_done, b_ok, b_runt;
  logic [31:0] a_val;
  logic [7:0] b_val;
  int checks = 0, errors = 0;
  logic iv_q = 1'b0;
  logic [31:0] tbl32 [256];
  logic [7:0] tbl8 [256];
  logic [7:0] frm [$];
  logic [33:0] eb32 [$], ab32 [$], eb8 [$], ab8 [$], ed32 [$], ad32 [$], ed8 [$], ad8 [$];

  always #5 clk = ~clk;

  crc_checker dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .out_data(a_od), .out_valid(a_ov), .out_last(a_ol), .crc_done(a_done),
    .crc_ok(a_ok), .crc_runt(a_runt), .crc_value(a_val)
  );

  crc_checker #(.CRC_WIDTH(8), .DATA_WIDTH(8), .POLYNOMIAL(8'h07), .SEED(8'h00)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .out_data(b_od), .out_valid(b_ov), .out_last(b_ol), .crc_done(b_done),
    .crc_ok(b_ok), .crc_runt(b_runt), .crc_value(b_val)
  );

  always @(posedge clk) iv_q <= in_valid;

  always @(negedge clk) begin
    if (rst_n) begin
      if (a_ov || b_ov) begin
        checks++;
        if (!iv_q) begin
          errors++;
          $display("FAIL stall_valid: out_valid a=%0b b=%0b after stalled cycle, want 0", a_ov, b_ov);
        end
      end
      if ((a_ol && !a_ov) || (b_ol && !b_ov)) begin
        checks++;
        errors++;
        $display("FAIL last_wo_valid: out_last a=%0b b=%0b without out_valid", a_ol, b_ol);
      end
      if (a_ov) ab32.push_back({25'h0, a_ol, a_od});
      if (b_ov) ab8.push_back({25'h0, b_ol, b_od});
      if (a_done) ad32.push_back({a_ok, a_runt, a_val});
      if (b_done) ad8.push_back({b_ok, b_runt, 24'h0, b_val});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] crc_ref(input int w, input int n);
    logic [31:0] mask = (w == 32) ? 32'hFFFFFFFF : 32'hFF;
    logic [31:0] c = (w == 32) ? 32'hFFFFFFFF : 32'h0;
    logic [7:0] idx;
    for (int i = 0; i < n; i++) begin
      idx = 8'(c >> (w - 8)) ^ frm[i];
      c = ((c << 8) ^ ((w == 32) ? tbl32[idx] : {24'h0, tbl8[idx]})) & mask;
    end
    return c;
  endfunction

  task automatic add_expect();
    int l = frm.size();
    for (int k = 0; k < 2; k++) begin
      int w = (k == 0) ? 32 : 8;
      int n = w / 8;
      logic [31:0] seed = (w == 32) ? 32'hFFFFFFFF : 32'h0;
      logic [31:0] c, fcs;
      if (l <= n) begin
        if (k == 0) ed32.push_back({2'b01, seed});
        else ed8.push_back({2'b01, seed});
      end else begin
        for (int i = 0; i < l - n; i++) begin
          if (k == 0) eb32.push_back({25'h0, i == l - n - 1, frm[i]});
          else eb8.push_back({25'h0, i == l - n - 1, frm[i]});
        end
        c = crc_ref(w, l - n);
        fcs = '0;
        for (int i = l - n; i < l; i++) fcs = (fcs << 8) | {24'h0, frm[i]};
        if (k == 0) ed32.push_back({fcs == c, 1'b0, c});
        else ed8.push_back({fcs == c, 1'b0, c});
      end
    end
  endtask

  task automatic send_frm(input bit gaps, input bit use_last);
    for (int i = 0; i < frm.size(); i++) begin
      int g = !gaps ? 0 : (i == frm.size() - 1) ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
      repeat (g) begin
        in_valid = 1'b0;
        in_data = 8'($urandom);
        in_last = 1'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data = frm[i];
      in_last = use_last && (i == frm.size() - 1);
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic cmpq(input string nm, input logic [33:0] e [$], input logic [33:0] a [$]);
    checks++;
    if (a.size() != e.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d entries, want %0d", nm, a.size(), e.size());
    end else begin
      for (int i = 0; i < e.size(); i++) begin
        checks++;
        if (a[i] !== e[i]) begin
          errors++;
          $display("FAIL %s[%0d]: got %h want %h", nm, i, a[i], e[i]);
        end
      end
    end
  endtask

  task automatic clear_q();
    eb32.delete(); ab32.delete(); eb8.delete(); ab8.delete();
    ed32.delete(); ad32.delete(); ed8.delete(); ad8.delete();
  endtask

  task automatic cmp(input string nm);
    cmpq({nm, "_pay32"}, eb32, ab32);
    cmpq({nm, "_pay8"}, eb8, ab8);
    cmpq({nm, "_done32"}, ed32, ad32);
    cmpq({nm, "_done8"}, ed8, ad8);
    if (ed32.size() > 0) begin
      checks++;
      if ({a_ok, a_runt, a_val} !== ed32[ed32.size()-1]) begin
        errors++;
        $display("FAIL %s_hold32: got %h want %h", nm, {a_ok, a_runt, a_val}, ed32[ed32.size()-1]);
      end
    end
    if (ed8.size() > 0) begin
      checks++;
      if ({b_ok, b_runt, 24'h0, b_val} !== ed8[ed8.size()-1]) begin
        errors++;
        $display("FAIL %s_hold8: got %h want %h", nm, {b_ok, b_runt, 24'h0, b_val}, ed8[ed8.size()-1]);
      end
    end
    clear_q();
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({a_od, a_ov, a_ol, a_done, a_ok, a_runt, a_val, b_od, b_ov, b_ol, b_done, b_ok, b_runt, b_val} !== '0) begin
      errors++;
      $display("FAIL %s: outputs a=%h/%b%b%b%b%b/%h b=%h/%b%b%b%b%b/%h, want all 0", nm,
               a_od, a_ov, a_ol, a_done, a_ok, a_runt, a_val, b_od, b_ov, b_ol, b_done, b_ok, b_runt, b_val);
    end
  endtask

  typedef struct {
    int len;
    logic [7:0] b [13];
    bit c32;
    logic ok32;
    logic runt32;
    logic [31:0] v32;
    bit c8;
    logic ok8;
    logic runt8;
    logic [7:0] v8;
  } vec_t;
  vec_t vt [5];

  task automatic load(input int k);
    frm.delete();
    for (int i = 0; i < vt[k].len; i++) frm.push_back(vt[k].b[i]);
  endtask

  initial begin
    logic [31:0] t;
    logic [7:0] t8;
    for (int v = 0; v < 256; v++) begin
      t = 32'(v) << 24;
      t8 = 8'(v);
      for (int j = 0; j < 8; j++) begin
        t = t[31] ? (t << 1) ^ 32'h04C11DB7 : t << 1;
        t8 = t8[7] ? (t8 << 1) ^ 8'h07 : t8 << 1;
      end
      tbl32[v] = t;
      tbl8[v] = t8;
    end
    vt[0] = '{13, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h03, 8'h76, 8'hE6, 8'hE7},
              1'b1, 1'b1, 1'b0, 32'h0376E6E7, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[1] = '{13, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h03, 8'h76, 8'hE6, 8'hE6},
              1'b1, 1'b0, 1'b0, 32'h0376E6E7, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[2] = '{10, '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4, 8'h00, 8'h00, 8'h00},
              1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 8'hF4};
    vt[3] = '{2, '{8'h80, 8'h89, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 8'h89};
    vt[4] = '{1, '{8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              1'b1, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 8'h00};

    repeat (2) tick();
    chk_zero("reset_state");
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 5; k++) begin
      load(k);
      add_expect();
      send_frm(1'b0, 1'b1);
      repeat (3) tick();
      if (vt[k].c32) begin
        checks++;
        if (ad32.size() == 0 || ad32[ad32.size()-1] !== {vt[k].ok32, vt[k].runt32, vt[k].v32}) begin
          errors++;
          $display("FAIL vec%0d_const32: got %h want %h", k,
                   (ad32.size() == 0) ? 34'h0 : ad32[ad32.size()-1], {vt[k].ok32, vt[k].runt32, vt[k].v32});
        end
      end
      if (vt[k].c8) begin
        checks++;
        if (ad8.size() == 0 || ad8[ad8.size()-1] !== {vt[k].ok8, vt[k].runt8, 24'h0, vt[k].v8}) begin
          errors++;
          $display("FAIL vec%0d_const8: got %h want %h", k,
                   (ad8.size() == 0) ? 34'h0 : ad8[ad8.size()-1], {vt[k].ok8, vt[k].runt8, 24'h0, vt[k].v8});
        end
      end
      cmp($sformatf("vec%0d", k));
    end

    for (int r = 0; r < 3; r++) begin
      load(0);
      add_expect();
      send_frm(1'b1, 1'b1);
      repeat (3) tick();
      cmp($sformatf("gaps%0d", r));
    end

    load(0);
    add_expect();
    send_frm(1'b0, 1'b1);
    add_expect();
    send_frm(1'b0, 1'b1);
    repeat (3) tick();
    cmp("back2back");

    load(0);
    while (frm.size() > 5) void'(frm.pop_back());
    send_frm(1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk_zero("reset_mid");
    checks++;
    if (ad32.size() != 0 || ad8.size() != 0) begin
      errors++;
      $display("FAIL abort_done: got %0d/%0d crc_done pulses, want 0/0", ad32.size(), ad8.size());
    end
    clear_q();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    load(0);
    add_expect();
    send_frm(1'b0, 1'b1);
    repeat (3) tick();
    cmp("after_reset");

    for (int r = 0; r < 30; r++) begin
      int plen = $urandom_range(0, 12);
      int w = $urandom_range(0, 1) ? 32 : 8;
      logic [31:0] c;
      frm.delete();
      for (int i = 0; i < plen; i++) frm.push_back(8'($urandom));
      c = crc_ref(w, plen);
      for (int k = w / 8 - 1; k >= 0; k--) frm.push_back(c[k*8 +: 8]);
      if ($urandom_range(0, 3) == 0) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'(1 << $urandom_range(0, 7));
      add_expect();
      send_frm(1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end
    repeat (3) tick();
    cmp("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
